pipelined_adder_n: RTL

Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the team's fixed 4-bit ripple-carry adder. Operands of WIDTH bits are split into STAGE_BITS-wide chunks, and each chunk is resolved in its own register stage, so the carry chain per cycle is only STAGE_BITS long. It accepts one operation per cycle through a valid/ready handshake, propagates backpressure, and reports carry, signed overflow and zero. It sits in the datapath wherever a wide add must close timing at full clock rate.

---
 rtl/adder_pkg.sv | 18 +
 rtl/chunk_adder.sv | 25 ++
 rtl/pipelined_adder_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: stage-count helper, width check
// and operation encoding.
package adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   function automatic int unsigned STAGES(input int unsigned width,
                                          input int unsigned stage_bits);
      return width / stage_bits;
   endfunction

   // Elaboration-time legality of a WIDTH/STAGE_BITS pair.
   function automatic bit width_ok(input int unsigned width, input int unsigned stage_bits);
      return (stage_bits != 0) && (width >= stage_bits) && ((width % stage_bits) == 0);
   endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational STAGE_BITS-wide ripple-carry adder from per-bit full adders.
module chunk_adder #(
   parameter int unsigned STAGE_BITS = 4
) (
   output logic [STAGE_BITS-1:0] sum,
   output logic                  carry_out,
   input  logic [STAGE_BITS-1:0] a,
   input  logic [STAGE_BITS-1:0] b,
   input  logic                  carry_in
);

   logic [STAGE_BITS:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = carry_in;
      for (int i = 0; i < STAGE_BITS; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
      carry_out = carry[STAGE_BITS];
   end

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined add/subtract: one STAGE_BITS chunk resolved per register stage, global
// stall backpressure, carry/overflow/zero flags registered with the final stage.
module pipelined_adder_n
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned STAGE_BITS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned S   = STAGES(WIDTH, STAGE_BITS);
   localparam int unsigned MSB = WIDTH - 1;

   if (!width_ok(WIDTH, STAGE_BITS)) begin : g_bad_width
      $error("pipelined_adder_n: WIDTH must be a non-zero multiple of STAGE_BITS");
   end

   logic                  advance;
   logic [WIDTH-1:0]      b_eff;
   logic                  c0;

   // Per-stage inputs: operands and partial sum as seen by stage k.
   logic [WIDTH-1:0]      a_in   [S];
   logic [WIDTH-1:0]      b_in   [S];
   logic [WIDTH-1:0]      sum_in [S];
   logic                  c_in   [S];
   logic                  v_in   [S];

   logic [STAGE_BITS-1:0] chunk_sum [S];
   logic [WIDTH-1:0]      sum_d     [S];
   logic                  c_d       [S];

   logic [WIDTH-1:0]      a_q   [S];
   logic [WIDTH-1:0]      b_q   [S];
   logic [WIDTH-1:0]      sum_q [S];
   logic                  c_q   [S];
   logic                  v_q   [S];

   logic                  ovf_d, ovf_q;
   logic                  zero_d, zero_q;

   assign advance  = !v_q[S-1] || out_ready;
   assign in_ready = advance;

   always_comb begin
      b_eff = b;
      c0    = carry_in;
      case (sub)
         OP_ADD: begin
            b_eff = b;
            c0    = carry_in;
         end
         OP_SUB: begin
            b_eff = ~b;
            c0    = ~carry_in;
         end
         default: ;
      endcase
   end

   always_comb begin
      a_in[0]   = a;
      b_in[0]   = b_eff;
      c_in[0]   = c0;
      sum_in[0] = '0;
      v_in[0]   = in_valid;
      for (int k = 1; k < S; k++) begin
         a_in[k]   = a_q[k-1];
         b_in[k]   = b_q[k-1];
         c_in[k]   = c_q[k-1];
         sum_in[k] = sum_q[k-1];
         v_in[k]   = v_q[k-1];
      end
   end

   for (genvar k = 0; k < S; k++) begin : g_stage
      chunk_adder #(
         .STAGE_BITS(STAGE_BITS)
      ) u_chunk (
         .sum      (chunk_sum[k]),
         .carry_out(c_d[k]),
         .a        (a_in[k][k*STAGE_BITS +: STAGE_BITS]),
         .b        (b_in[k][k*STAGE_BITS +: STAGE_BITS]),
         .carry_in (c_in[k])
      );
   end

   // Completed lower chunks ride along; stage k fills in chunk k.
   always_comb begin
      for (int k = 0; k < S; k++) begin
         sum_d[k] = sum_in[k];
         sum_d[k][k*STAGE_BITS +: STAGE_BITS] = chunk_sum[k];
      end
   end

   always_comb begin
      ovf_d  = (a_in[S-1][MSB] == b_in[S-1][MSB]) && (sum_d[S-1][MSB] != a_in[S-1][MSB]);
      zero_d = (sum_d[S-1] == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < S; k++) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < S; k++) begin
            v_q[k]   <= v_in[k];
            a_q[k]   <= a_in[k];
            b_q[k]   <= b_in[k];
            sum_q[k] <= sum_d[k];
            c_q[k]   <= c_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign out_valid = v_q[S-1];
   assign sum       = sum_q[S-1];
   assign carry_out = c_q[S-1];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
